keypad_debounce: RTL and testbench

- Consumes the raw {row one-hot, col one-hot} key code from the keypad scanner.
- Debounces the press and freezes the scanner on the pressed row while the key is held.
- Decodes the key to a hex digit, emits a one-cycle new-key strobe and keeps a two-digit history for the seven-segment display mux.
- Registers one key per physical press. Ignores glitches, bounces and extra keys pressed while one is held.

---
 rtl/keypad_debounce.sv | 106 ++++++++++
 tb/tb_keypad_debounce.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
// keypad_debounce: debounces a scanned key, holds the scanner row, decodes to hex and keeps a two-digit history
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_val,
    output logic       scan_hold,
    output logic [3:0] key_hex,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // key map packed row-major, entry {row,col} at nibble row*4+col
    localparam logic [63:0] HEX_LUT = 64'hDF0E_C987_B654_A321;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cand_q, cand_d;
    logic             hold_q, valid_q, accept;
    logic [3:0]       hex_q, new_q, old_q;
    logic             key_ok, match;
    logic [1:0]       row, col;
    logic [3:0]       cand_hex;

    assign key_ok   = $onehot(key_val[7:4]) && $onehot(key_val[3:0]);
    assign match    = key_val == cand_q;
    assign row      = cand_q[5] ? 2'd1 : cand_q[6] ? 2'd2 : cand_q[7] ? 2'd3 : 2'd0;
    assign col      = cand_q[1] ? 2'd1 : cand_q[2] ? 2'd2 : cand_q[3] ? 2'd3 : 2'd0;
    assign cand_hex = HEX_LUT[{row, col, 2'b00} +: 4];

    // press/release state machine; the counter saturates at CNT_MAX and clears on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (key_ok) begin
                cand_d  = key_val;
                cnt_d   = '0;
                state_d = DEBOUNCE;
            end
            DEBOUNCE: if (!match) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                state_d = HELD;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            HELD: if (!match) begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            default: if (match) begin
                cnt_d   = '0;
                state_d = HELD;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase
    end

    // state, registered scanner hold, strobe and digit history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            hold_q  <= 1'b0;
            valid_q <= 1'b0;
            hex_q   <= '0;
            new_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            hold_q  <= state_d != IDLE;
            valid_q <= accept;
            if (accept) begin
                hex_q <= cand_hex;
                new_q <= cand_hex;
                old_q <= new_q;
            end
        end
    end

    assign scan_hold = hold_q;
    assign key_hex   = hex_q;
    assign key_valid = valid_q;
    assign digit_new = new_q;
    assign digit_old = old_q;
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: random and directed stimulus against a run-length reference model with a scoreboard queue
module tb_keypad_debounce;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key_val = 8'h00;
    logic       scan_hold, key_valid;
    logic [3:0] key_hex, digit_new, digit_old;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int cyc = 0;
    logic [16:0] expq[$];

    // reference model: busy = a candidate is latched, held = it was accepted,
    // run = consecutive matching samples (pressing) or mismatching samples (held)
    logic       m_busy = 1'b0, m_held = 1'b0, m_acc = 1'b0;
    int         m_run = 0;
    logic [7:0] m_cand = 8'h00;
    logic [3:0] m_hex = 4'h0, m_new = 4'h0, m_old = 4'h0;

    always #5 clk = ~clk;

    keypad_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk),
        .reset(reset),
        .key_val(key_val),
        .scan_hold(scan_hold),
        .key_hex(key_hex),
        .key_valid(key_valid),
        .digit_new(digit_new),
        .digit_old(digit_old)
    );

    function automatic logic [3:0] dec(input logic [7:0] k);
        logic [3:0] t [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        int r = 0;
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[4+i]) r = i;
            if (k[i]) c = i;
        end
        return t[r*4+c];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_held = 0; m_acc = 0; m_run = 0; m_cand = 0;
        m_hex = 0; m_new = 0; m_old = 0;
    endtask

    task automatic model(input logic [7:0] k);
        m_acc = 0;
        if (!reset) model_clear();
        else if (!m_busy) begin
            if ($countones(k[7:4]) == 1 && $countones(k[3:0]) == 1) begin
                m_busy = 1; m_held = 0; m_cand = k; m_run = 0;
            end
        end else if (!m_held) begin
            if (k != m_cand) m_busy = 0;
            else begin
                m_run++;
                if (m_run == N) begin
                    m_held = 1; m_run = 0; m_acc = 1;
                    m_hex = dec(m_cand); m_old = m_new; m_new = m_hex;
                end
            end
        end else if (k == m_cand) m_run = 0;
        else begin
            m_run++;
            if (m_run == N + 1) m_busy = 0;
        end
    endtask

    task automatic step(input logic [7:0] k);
        key_val = k;
        @(posedge clk);
        cyc++;
        model(k);
        expq.push_back({m_busy, m_hex, m_acc, m_new, m_old});
        #1;
    endtask

    task automatic steps(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    // monitor: compare every presented output cycle against the oldest expectation
    always @(negedge clk) begin
        if (key_valid) strobes++;
        if (expq.size() > 0)
            chk("outputs{hold,hex,valid,new,old}",
                {scan_hold, key_hex, key_valid, digit_new, digit_old}, expq.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        logic [7:0] k;
        // reset and idle
        steps(8'h12, 3);
        reset = 1'b1;
        steps(8'h00, 10);
        chk("idle_hold", scan_hold, 0);
        chk("idle_strobes", strobes, 0);
        // single clean press of row0/col1
        s = strobes;
        step(8'h12);
        chk("hold_after_first_sample", scan_hold, 1);
        steps(8'h12, 3);
        chk("no_strobe_early", key_valid, 0);
        step(8'h12);
        chk("strobe_at_n", key_valid, 1);
        steps(8'h12, 5);
        chk("press_strobes", strobes - s, 1);
        chk("press_hex", key_hex, 4'h2);
        chk("press_old", digit_old, 0);
        steps(8'h00, 8);
        // press bounce: first attempt rejected
        s = strobes;
        steps(8'h81, 2);
        steps(8'h00, 1);
        steps(8'h81, 8);
        chk("bounce_strobes", strobes - s, 1);
        chk("bounce_hex", key_hex, 4'hE);
        steps(8'h00, 8);
        // release bounce
        s = strobes;
        steps(8'h44, 8);
        for (int i = 0; i < 3; i++) begin
            steps(8'h00, 2);
            steps(8'h44, 2);
        end
        steps(8'h00, 4);
        chk("release_hold_before", scan_hold, 1);
        steps(8'h00, 1);
        chk("release_hold_after", scan_hold, 0);
        steps(8'h00, 1);
        chk("release_strobes", strobes - s, 1);
        chk("release_hex", key_hex, 4'h9);
        // history and multi-key rejection
        steps(8'h12, 8);
        steps(8'h00, 8);
        steps(8'h28, 8);
        steps(8'h00, 8);
        s = strobes;
        steps(8'h13, 6);
        chk("multikey_strobes", strobes - s, 0);
        chk("multikey_hold", scan_hold, 0);
        chk("hist_old", digit_old, 4'h2);
        chk("hist_new", digit_new, 4'hB);
        // asynchronous reset while held
        steps(8'h81, 8);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        chk("async_rst_hold", scan_hold, 0);
        chk("async_rst_digits", {digit_new, digit_old, key_hex}, 0);
        steps(8'h81, 2);
        reset = 1'b1;
        s = strobes;
        steps(8'h81, 8);
        chk("post_rst_strobes", strobes - s, 1);
        chk("post_rst_hex", key_hex, 4'hE);
        steps(8'h00, 8);
        // random traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 4))
                0: k = 8'h00;
                1: k = 8'h13;
                2: k = 8'($urandom);
                default: k = {4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3))};
            endcase
            steps(k, $urandom_range(1, 7));
        end
        steps(8'h00, 10);
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
